imem_fetch_responder: RTL

- Responder side of the instruction-fetch interface.
- The fetch stage (initiator) issues word-aligned PC requests. This block returns the instruction plus its PC through a small response FIFO.
- The response side honours ID-stage backpressure (stall) and a jump/branch flush.
- A loader write port fills the instruction store before or between runs. It replaces the combinational ROM with a handshaked, stallable memory.

---
 rtl/imem_fetch_responder_pkg.sv | 27 ++
 rtl/imem_fetch_responder_fifo.sv | 85 ++++++++
 rtl/imem_fetch_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared fetch-pipeline definitions: instruction/PC widths, the NOP word
// returned for faulting fetches, and the response record carried through
// the response FIFO.
package imem_fetch_responder_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetch response as it sits in the FIFO.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               err;
  } fetch_rsp_t;

  localparam int RSP_W = $bits(fetch_rsp_t);

  // A fetch faults when the PC is not word aligned or points beyond the
  // 2**addr_w-word store (any byte-address bit above the word index set).
  function automatic logic fetch_addr_err(input logic [PC_W-1:0] addr,
                                          input int addr_w);
    return (addr[1:0] != 2'b00) ||
           ((addr >> (addr_w + 32'sd2)) != {PC_W{1'b0}});
  endfunction

endpackage

// File: rtl/imem_fetch_responder_fifo.sv
// sync_fifo: small synchronous FIFO with push/pop/flush and an occupancy count.
// Reusable as a skid buffer for later pipeline stages.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears entries too)
//   flush           drop all entries; a pop in the same cycle is ignored
//   push, push_data write one entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   head_data       current head entry (holds its last value when empty)
//   not_empty       head entry is valid
//   count           entries held, 0..DEPTH
module sync_fifo #(
  parameter int  WIDTH = 65,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;

  // Qualify push/pop against occupancy and compute wrapped next pointers.
  always_comb begin
    do_push_s = push && (count_r != CNT_W'(DEPTH));
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    if (rd_ptr_r == PTR_W'(DEPTH - 1)) begin
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end
    if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end
  end

  // Pointer and occupancy registers; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_r <= do_pop_s  ? rd_ptr_nxt_s : rd_ptr_r;
      wr_ptr_r <= do_push_s ? wr_ptr_nxt_s : wr_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[PTR_W'(i)] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign not_empty = (count_r != {CNT_W{1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: responder side of the instruction-fetch interface.
// Holds a loader-written instruction store, answers word-aligned PC
// requests through a small response FIFO that honours stall and flush.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready/req_addr     fetch request handshake and byte PC
//   rsp_valid/rsp_ready              response handshake (rsp_ready = !stall)
//   rsp_instr/rsp_pc/rsp_err         FIFO head: instruction, echoed PC, fault
//   flush                            squash all queued responses
//   ld_en/ld_addr/ld_data            loader write port into the store
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [PC_W-1:0]   rsp_pc,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INSTR_W-1:0] ld_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [INSTR_W-1:0] store_r [2**ADDR_W];
  logic [INSTR_W-1:0] rd_word_s;
  logic               addr_err_s;
  logic               req_ready_s;
  logic               accept_s;
  logic               pop_s;
  fetch_rsp_t         push_rsp_s;
  fetch_rsp_t         head_rsp_s;
  logic [RSP_W-1:0]   head_bits_s;
  logic               fifo_not_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;

  // Loader writes; the store is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      store_r[ld_addr] <= ld_data;
    end
  end

  // Request side: combinational store read, fault detection and the
  // accept condition. req_ready never looks at rsp_ready.
  always_comb begin
    rd_word_s   = store_r[req_addr[ADDR_W+1:2]];
    addr_err_s  = fetch_addr_err(req_addr, ADDR_W);
    req_ready_s = !reset && !flush && !ld_en &&
                  (fifo_count_s < CNT_W'(FIFO_DEPTH));
    accept_s    = req_valid && req_ready_s;
    push_rsp_s.pc  = req_addr;
    push_rsp_s.err = addr_err_s;
    if (addr_err_s) begin
      push_rsp_s.instr = NOP_INSTR;
    end else begin
      push_rsp_s.instr = rd_word_s;
    end
  end

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (accept_s),
    .push_data (push_rsp_s),
    .pop       (pop_s),
    .head_data (head_bits_s),
    .not_empty (fifo_not_empty_s),
    .count     (fifo_count_s)
  );

  // Response side: head of FIFO, forced quiet while reset is asserted.
  always_comb begin
    head_rsp_s = fetch_rsp_t'(head_bits_s);
    pop_s      = fifo_not_empty_s && rsp_ready;
    req_ready  = req_ready_s;
    if (reset) begin
      rsp_valid = 1'b0;
      rsp_instr = NOP_INSTR;
      rsp_pc    = {PC_W{1'b0}};
      rsp_err   = 1'b0;
    end else begin
      rsp_valid = fifo_not_empty_s;
      rsp_instr = head_rsp_s.instr;
      rsp_pc    = head_rsp_s.pc;
      rsp_err   = head_rsp_s.err;
    end
  end

endmodule
